lut_delay_cal: RTL
==================

LUT_DELAY_CAL -- requirements
Module: lut_delay_cal

Interface
REQ-001 The module SHALL have parameter CNT_W, default 16, meaning the width of the latency counter and result.
REQ-002 The module SHALL have parameter TIMEOUT, default 1023, meaning the maximum count before a measurement is aborted; it SHALL be less than 2^CNT_W-1.
REQ-003 The module SHALL have parameter SYNC_STAGES, default 2, meaning the number of flip-flops in the ret_i synchronizer; the minimum is 2.
REQ-004 The module SHALL have port clk, input, width 1, the single clock for all logic.
REQ-005 The module SHALL have port rst_n, input, width 1, the reset (asynchronous, active-low).
REQ-006 The module SHALL have port start, input, width 1, a measurement request sampled only in IDLE.
REQ-007 The module SHALL have port launch_o, output, width 1, the registered edge driven into the delay line input.
REQ-008 The module SHALL have port ret_i, input, width 1, the delay line output, treated as asynchronous.
REQ-009 The module SHALL have port busy, output, width 1, which is high whenever the state is not IDLE.
REQ-010 The module SHALL have port done, output, width 1, a one-cycle pulse when a result is valid.
REQ-011 The module SHALL have port timeout, output, width 1, sticky for the last measurement and valid with done.
REQ-012 The module SHALL have port latency_o, output, width CNT_W, the measured latency in clk cycles, held until the next done.

Function
REQ-013 The module SHALL synchronize ret_i through SYNC_STAGES flip-flops (ret_s); no other logic SHALL sample ret_i.
REQ-014 The FSM SHALL have states IDLE, ARM, FIRE, and DONE.
REQ-015 On start high in IDLE, the FSM SHALL go to ARM, clear timeout, drive launch_o low, and clear cnt.
REQ-016 In ARM, cnt SHALL increment each cycle; ret_s==0 SHALL cause a transition to FIRE; cnt==TIMEOUT SHALL cause a transition to DONE with timeout=1.
REQ-017 On entering FIRE, launch_o SHALL go high and cnt SHALL be set to 0; cnt SHALL then increment once per cycle while ret_s==0.
REQ-018 In FIRE, the first cycle with ret_s==1 SHALL capture cnt into the result and cause a transition to DONE; cnt==TIMEOUT SHALL cause a transition to DONE with timeout=1 and result all-ones.
REQ-019 In DONE, the module SHALL pulse done for exactly one cycle, update latency_o, drive launch_o low, and return to IDLE in the next cycle.
REQ-020 With ret_i connected directly to launch_o, latency_o SHALL equal SYNC_STAGES.
REQ-021 start asserted while busy SHALL be ignored, with no queuing.
REQ-022 start held high continuously SHALL give back-to-back measurements with one IDLE cycle between them.
REQ-023 cnt SHALL saturate at TIMEOUT and never wrap.

Reset
REQ-024 While rst_n is low, the module SHALL hold state=IDLE, launch_o=0, busy=0, done=0, timeout=0, latency_o=0, cnt=0, and all synchronizer flip-flops at 0.
REQ-025 Reset asserted mid-measurement SHALL abort immediately with no done pulse; after release, the module SHALL wait in IDLE for start.

Configuration
REQ-026 When macro LUT_DELAY_CAL_AVG_EN is defined, each start SHALL run 8 consecutive ARM/FIRE cycles, accumulate results in a CNT_W+3-bit sum, and emit a single done with latency_o = sum>>3 (truncated).
REQ-027 With LUT_DELAY_CAL_AVG_EN defined, any sub-measurement timeout SHALL end the sequence at once with timeout=1 and latency_o all-ones.
REQ-028 Without LUT_DELAY_CAL_AVG_EN, each start SHALL produce exactly one measurement and one done, and no accumulator SHALL be present.

Verification
REQ-029 The bench SHALL cover: ret_i tied to launch_o, start pulse -> one done, latency_o=2, timeout=0.
REQ-030 The bench SHALL cover: ret_i = launch_o delayed 5 clk cycles by a model -> latency_o=7.
REQ-031 The bench SHALL cover: ret_i stuck at 0 -> done after TIMEOUT+1 FIRE cycles, timeout=1, latency_o=16'hFFFF.
REQ-032 The bench SHALL cover: ret_i stuck at 1 -> ARM times out, done with timeout=1 and launch_o never rising.
REQ-033 The bench SHALL cover: rst_n pulled low 3 cycles into FIRE -> no done, launch_o=0 and busy=0 at once, and a later start measuring correctly.
REQ-034 The bench SHALL cover: with AVG_EN, model delays 0,0,0,0,8,8,8,8 cycles -> single done with latency_o=6.

Source files
------------

// File: rtl/lut_delay_cal.sv
// Delay-line latency calibrator: fires an edge into a LUT delay line and counts clk cycles until it returns.
// Optional macro LUT_DELAY_CAL_AVG_EN averages eight back-to-back measurements per start.
module lut_delay_cal #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 1023,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             launch_o,
  input  logic             ret_i,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] latency_o
);

  typedef enum logic [1:0] {IDLE, ARM, FIRE, DONE} state_e;

  localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ALL1 = '1;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ret_s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       lat_q, lat_d;
  logic                   launch_q, launch_d;
  logic                   tmo_q, tmo_d;

`ifdef LUT_DELAY_CAL_AVG_EN
  logic [CNT_W+2:0]       sum_q, sum_d;
  logic [CNT_W+2:0]       sum_next;
  logic [2:0]             sub_q, sub_d;
`endif

  // ret_i is asynchronous to clk; only the last synchronizer stage feeds the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ret_i};
    end
  end

  assign ret_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lat_q    <= '0;
      launch_q <= 1'b0;
      tmo_q    <= 1'b0;
`ifdef LUT_DELAY_CAL_AVG_EN
      sum_q    <= '0;
      sub_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lat_q    <= lat_d;
      launch_q <= launch_d;
      tmo_q    <= tmo_d;
`ifdef LUT_DELAY_CAL_AVG_EN
      sum_q    <= sum_d;
      sub_q    <= sub_d;
`endif
    end
  end

`ifdef LUT_DELAY_CAL_AVG_EN
  assign sum_next = sum_q + {3'b000, cnt_q};
`endif

  // Result and timeout flag are loaded on the edge into DONE so they are valid alongside done.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lat_d    = lat_q;
    launch_d = launch_q;
    tmo_d    = tmo_q;
`ifdef LUT_DELAY_CAL_AVG_EN
    sum_d    = sum_q;
    sub_d    = sub_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ARM;
          tmo_d    = 1'b0;
          launch_d = 1'b0;
          cnt_d    = '0;
`ifdef LUT_DELAY_CAL_AVG_EN
          sum_d    = '0;
          sub_d    = '0;
`endif
        end
      end
      ARM: begin
        if (!ret_s) begin
          state_d  = FIRE;
          launch_d = 1'b1;
          cnt_d    = '0;
        end else if (cnt_q == TMO) begin
          state_d  = DONE;
          tmo_d    = 1'b1;
          lat_d    = ALL1;
          launch_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIRE: begin
        if (ret_s) begin
          launch_d = 1'b0;
`ifdef LUT_DELAY_CAL_AVG_EN
          if (sub_q == 3'd7) begin
            state_d = DONE;
            lat_d   = sum_next[CNT_W+2:3];
          end else begin
            state_d = ARM;
            sum_d   = sum_next;
            sub_d   = sub_q + 1'b1;
            cnt_d   = '0;
          end
`else
          state_d = DONE;
          lat_d   = cnt_q;
`endif
        end else if (cnt_q == TMO) begin
          state_d  = DONE;
          tmo_d    = 1'b1;
          lat_d    = ALL1;
          launch_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    launch_o  = launch_q;
    timeout   = tmo_q;
    latency_o = lat_q;
  end

endmodule
